// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single RegisterFile write port between two writeback
//   requesters (req0 = ALU result, req1 = memory load) with round-robin
//   arbitration and valid/ready handshakes.
//   Also keeps a busy scoreboard of destinations allocated at issue whose
//   writeback has not yet reached the write port.
//
// Parameters
//   DW : writeback data width
//   AW : register address width (2**AW registers)
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   req0_valid/ready/dst/data  ALU writeback handshake
//   req1_valid/ready/dst/data  load writeback handshake
//   alloc_valid, alloc_dst  issue-stage destination allocation
//   regwrite, regdst, writedata  registered RegisterFile write port
//   busy_mask               bit n set = register n has a pending writeback
//   last_grant              most recently granted requester (0 ALU, 1 load)
//
// Optional feature macro: REGFILE_WB_R0_ZERO_EN
//   When defined, register 0 is hard-wired: writes to it complete their
//   handshake but do not assert regwrite, and allocations of it are ignored.

module regfile_wb_arbiter #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [AW-1:0]    req0_dst,
  input  logic [DW-1:0]    req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [AW-1:0]    req1_dst,
  input  logic [DW-1:0]    req1_data,
  input  logic             alloc_valid,
  input  logic [AW-1:0]    alloc_dst,
  output logic             regwrite,
  output logic [AW-1:0]    regdst,
  output logic [DW-1:0]    writedata,
  output logic [2**AW-1:0] busy_mask,
  output logic             last_grant
);

  logic          gnt0;
  logic          gnt1;
  logic          xfer;
  logic [AW-1:0] sel_dst;
  logic [DW-1:0] sel_data;
  logic          wr_en;
  logic          alloc_en;
  logic [2**AW-1:0] busy_next;

  // Round-robin: a lone requester always wins; on contention the one
  // that was not granted last time goes first. Readiness is held low
  // while reset is asserted so no handshake completes in that cycle.
  always_comb begin
    gnt0 = rst_n && req0_valid && (!req1_valid || last_grant);
    gnt1 = rst_n && req1_valid && (!req0_valid || !last_grant);
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign xfer       = gnt0 || gnt1;
  assign sel_dst    = gnt1 ? req1_dst  : req0_dst;
  assign sel_data   = gnt1 ? req1_data : req0_data;

`ifdef REGFILE_WB_R0_ZERO_EN
  assign wr_en    = xfer && (sel_dst != '0);
  assign alloc_en = alloc_valid && (alloc_dst != '0);
`else
  assign wr_en    = xfer;
  assign alloc_en = alloc_valid;
`endif

  // Clear for the completing writeback first, then set for a new
  // allocation, so a same-edge alloc of the same register keeps it busy.
  always_comb begin
    busy_next = busy_mask;
    if (xfer)
      busy_next[sel_dst] = 1'b0;
    if (alloc_en)
      busy_next[alloc_dst] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regwrite   <= 1'b0;
      regdst     <= '0;
      writedata  <= '0;
      busy_mask  <= '0;
      last_grant <= 1'b0;
    end else begin
      regwrite  <= wr_en;
      busy_mask <= busy_next;
      if (xfer) begin
        regdst     <= sel_dst;
        writedata  <= sel_data;
        last_grant <= gnt1;
      end
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single RegisterFile write port (regwrite/regdst/writedata) between two writeback requesters: ALU result (req0) and memory load (req1).
- Round-robin arbitration with valid/ready handshakes; drives registered write-port signals into RegisterFile.
- Keeps a 16-entry busy scoreboard: destinations allocated at issue stay busy until their writeback reaches the write port. Decode uses this mask to stall reads of pending registers.

Parameters:
- DW, 16, data width of writeback value and RegisterFile word
- AW, 4, register address width; register count = 2**AW

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- req0_valid  input  1  ALU writeback request
- req0_ready  output  1  ALU request accepted this cycle
- req0_dst  input  AW  ALU destination register
- req0_data  input  DW  ALU writeback value
- req1_valid  input  1  load writeback request
- req1_ready  output  1  load request accepted this cycle
- req1_dst  input  AW  load destination register
- req1_data  input  DW  load writeback value
- alloc_valid  input  1  issue stage allocates a destination
- alloc_dst  input  AW  register being allocated
- regwrite  output  1  RegisterFile write enable
- regdst  output  AW  RegisterFile write address
- writedata  output  DW  RegisterFile write data
- busy_mask  output  2**AW  bit n = register n has writeback pending
- last_grant  output  1  requester granted most recently (0 = ALU, 1 = load)

Behaviour:
- Reset: synchronous, active-low. Only when rst_n is sampled low at a rising clk edge, clear regwrite, regdst, writedata, busy_mask and last_grant to 0. Reset overrides every other event in that cycle: no handshake is accepted, any in-flight regwrite pulse is dropped, and all allocations are discarded.
- Grant (combinational from current inputs and last_grant):
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester that is not last_grant.
  - reqN_ready = grant to N, and is 0 during the reset cycle.
  - Ready never depends on data or dst.
- Handshake: a transfer occurs when reqN_valid and reqN_ready are both 1 at a clk edge. A requester holds valid, dst and data stable until it sees ready. The requester not granted sees ready = 0 and retries next cycle.
- Write-port latency: 1 cycle. A transfer at edge k gives regwrite = 1, with regdst and writedata equal to the granted dst and data, during cycle k..k+1. regwrite is 0 in any cycle with no transfer at the previous edge.
- Throughput: one writeback per cycle. With both requesters valid continuously, grants alternate 0,1,0,1.
- last_grant updates only on a transfer.
- Scoreboard:
  - alloc_valid at an edge sets busy_mask[alloc_dst].
  - A transfer at an edge clears busy_mask[dst of that transfer] at the same edge.
  - Set and clear of the same register at the same edge: set wins (new owner).
  - A transfer to a non-busy register is legal: the write proceeds and the mask is unchanged.
  - Multiple allocations of one register before its writeback: a single bit, cleared by the first writeback.
- Same-dst collision between req0 and req1 in one cycle: ordered by round-robin only. Both writes occur on consecutive cycles; the second one wins in RegisterFile.
- Register 0 is writable (same as any other register) unless the optional feature is enabled.

Optional Feature:
- Macro: REGFILE_WB_R0_ZERO_EN
- Defined:
  - A transfer with dst = 0 completes the handshake normally but produces regwrite = 0 the next cycle.
  - regdst and writedata still update.
  - alloc to register 0 is ignored, so busy_mask[0] stays 0.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset: hold rst_n = 0 for 2 edges with req0_valid = 1 -> req0_ready = 0, regwrite = 0, busy_mask = 16'h0000, last_grant = 0; release -> first transfer accepted.
- Single ALU write: req0 dst = 5, data = 16'h0024 for one cycle -> req0_ready = 1; next cycle regwrite = 1, regdst = 5, writedata = 16'h0024; following cycle regwrite = 0.
- Contention: both valid for 4 cycles (req0 dst = 1, data = 16'h0007; req1 dst = 2, data = 16'h00AA); last_grant = 0 at start -> write-port sequence is reg2, reg1, reg2, reg1; each ready pulses on alternate cycles.
- Scoreboard: alloc 3 then alloc 7 -> busy_mask = 16'h0088; req1 writes dst 3 -> mask 16'h0080 one edge after the transfer; alloc 7 together with a req0 transfer to dst 7 at the same edge -> bit 7 remains 1.
- Mid-operation reset: a transfer at edge k and rst_n = 0 at edge k+1 -> regwrite = 0 after edge k+1 and busy_mask cleared.
- REGFILE_WB_R0_ZERO_EN build: req0 dst = 0, data = 16'h0007 -> req0_ready = 1, regwrite stays 0; alloc dst = 0 -> busy_mask = 0. Without the macro: regwrite = 1, regdst = 0.
